// File: rtl/sdram_port_arbiter.sv
// Two-master round-robin arbiter in front of the SDRAM controller slave port.
// Commands pass straight through; an owner-tag FIFO steers each read return to its issuer.
module sdram_port_arbiter #(
  parameter int unsigned ADDR_W      = 25,
  parameter int unsigned MAX_PENDING = 8
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [31:0]       m0_writedata,
  input  logic [3:0]        m0_byteenable,
  output logic              m0_waitrequest,
  output logic [31:0]       m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [31:0]       m1_writedata,
  input  logic [3:0]        m1_byteenable,
  output logic              m1_waitrequest,
  output logic [31:0]       m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] s_address,
  output logic              s_read,
  output logic              s_write,
  output logic [31:0]       s_writedata,
  output logic [3:0]        s_byteenable,
  input  logic              s_waitrequest,
  input  logic [31:0]       s_readdata,
  input  logic              s_readdatavalid,
  output logic              err_orphan
);

  localparam int unsigned PTR_W = $clog2(MAX_PENDING);
  localparam int unsigned CNT_W = $clog2(MAX_PENDING + 1);

  typedef enum logic {ST_OPEN, ST_HELD} arb_state_e;

  arb_state_e             state_q, state_d;
  logic                   owner_q, owner_d;
  logic                   last_q, last_d;
  logic                   err_q, err_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [MAX_PENDING-1:0] fifo_q;

  logic full_c, pending_c, elig0_c, elig1_c;
  logic gnt_vld_c, gnt_id_c, accept_c, push_c, pop_c, head_c;

  assign full_c    = (count_q == CNT_W'(MAX_PENDING));
  assign pending_c = (count_q != '0);
  assign elig0_c   = m0_write | (m0_read & ~full_c);
  assign elig1_c   = m1_write | (m1_read & ~full_c);
  assign head_c    = fifo_q[rd_ptr_q];

  // Grant: held command keeps its owner; otherwise round-robin among eligible masters
  always_comb begin
    gnt_vld_c = 1'b0;
    gnt_id_c  = 1'b0;
    if (state_q == ST_HELD) begin
      gnt_vld_c = 1'b1;
      gnt_id_c  = owner_q;
    end else if (elig0_c && elig1_c) begin
      gnt_vld_c = 1'b1;
      gnt_id_c  = ~last_q;
    end else if (elig0_c) begin
      gnt_vld_c = 1'b1;
    end else if (elig1_c) begin
      gnt_vld_c = 1'b1;
      gnt_id_c  = 1'b1;
    end
  end

  assign s_address    = gnt_id_c ? m1_address    : m0_address;
  assign s_writedata  = gnt_id_c ? m1_writedata  : m0_writedata;
  assign s_byteenable = gnt_id_c ? m1_byteenable : m0_byteenable;
  assign s_read       = ~reset_reset & gnt_vld_c & (gnt_id_c ? m1_read  : m0_read);
  assign s_write      = ~reset_reset & gnt_vld_c & (gnt_id_c ? m1_write : m0_write);

  assign m0_waitrequest = reset_reset | ~(gnt_vld_c & ~gnt_id_c) | s_waitrequest;
  assign m1_waitrequest = reset_reset | ~(gnt_vld_c &  gnt_id_c) | s_waitrequest;

  assign accept_c = (s_read | s_write) & ~s_waitrequest;
  assign push_c   = accept_c & s_read;
  assign pop_c    = s_readdatavalid & pending_c;

  assign m0_readdata      = s_readdata;
  assign m1_readdata      = s_readdata;
  assign m0_readdatavalid = ~reset_reset & pop_c & ~head_c;
  assign m1_readdatavalid = ~reset_reset & pop_c &  head_c;
  assign err_orphan       = err_q;

  // Next-state: grant hold, round-robin pointer, tag FIFO bookkeeping, orphan flag
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    count_d  = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    wr_ptr_d = wr_ptr_q + PTR_W'(push_c);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_c);
    err_d    = err_q | (s_readdatavalid & ~pending_c);
    if (accept_c) begin
      state_d = ST_OPEN;
      last_d  = gnt_id_c;
    end else if (s_read || s_write) begin
      state_d = ST_HELD;
      owner_d = gnt_id_c;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q  <= ST_OPEN;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      err_q    <= err_d;
    end
  end

  // Tag storage needs no reset; pointers and count define validity
  always_ff @(posedge clk_clk) begin
    if (push_c) fifo_q[wr_ptr_q] <= gnt_id_c;
  end

endmodule

// File: doc/sdram_port_arbiter.md
# sdram_port_arbiter

Two-master Avalon-MM arbiter that shares the single SDRAM controller slave port (32-bit data, 25-bit word address) between the Nios II data master (port 0) and a second bus master such as a DMA or frame engine (port 1). Round-robin grants per accepted command. Commands pass through combinationally. Pipelined reads are tracked in an owner-tag FIFO, so each `readdatavalid` returns to the master that issued the read. Sits between the masters and the SDRAM controller inside `nios_system`.

## Interface
Parameters:
- `ADDR_W`, 25, word address width (13 row + 10 col + 2 bank)
- `MAX_PENDING`, 8, maximum outstanding reads; power of two, ≥2

Ports:
- `clk_clk`  in  1  system clock
- `reset_reset`  in  1  synchronous, active-high reset
- `mN_address`  in  ADDR_W  master N word address (N = 0, 1)
- `mN_read`, `mN_write`  in  1  master N command strobes; at most one high at a time
- `mN_writedata`  in  32  master N write data
- `mN_byteenable`  in  4  master N byte enables
- `mN_waitrequest`  out  1  high = master N command not accepted this cycle
- `mN_readdata`  out  32  read data, broadcast to both masters
- `mN_readdatavalid`  out  1  read data valid for master N
- `s_address`  out  ADDR_W  to SDRAM controller
- `s_read`, `s_write`  out  1  to SDRAM controller
- `s_writedata`  out  32  to SDRAM controller
- `s_byteenable`  out  4  to SDRAM controller
- `s_waitrequest`  in  1  from SDRAM controller
- `s_readdata`  in  32  from SDRAM controller
- `s_readdatavalid`  in  1  from SDRAM controller
- `err_orphan`  out  1  sticky: `s_readdatavalid` arrived while the tag FIFO was empty

## Operation
- State registers:
  - `last` (1 bit): last master granted.
  - `lock` (1 bit) and `lock_owner` (1 bit): command hold.
  - Tag FIFO: depth `MAX_PENDING`, 1-bit entries, with `count` (0..MAX_PENDING).
  - `err_orphan` flag.
- Eligibility: master N is eligible if `mN_write`, or if `mN_read` and `count < MAX_PENDING`.
- Grant (combinational):
  - If `lock`, grant goes to `lock_owner`.
  - Otherwise, if exactly one master is eligible, grant goes to it.
  - If both are eligible, grant goes to `~last`.
  - If neither is eligible, there is no grant.
- Slave drive:
  - `s_*` mirrors the granted master's address, data, byteenable and strobes.
  - With no grant, `s_read` = `s_write` = 0 and address/data are don't-care (drive master 0 fields).
- Waitrequest:
  - The granted master sees `mN_waitrequest = s_waitrequest`.
  - A non-granted or ineligible master sees `mN_waitrequest = 1`.
  - An idle master sees 1; masters ignore it.
- Accept: a command is accepted when `(s_read | s_write) & ~s_waitrequest`. On accept:
  - `last` ← grantee, `lock` ← 0.
  - For a read, push the grantee ID to the FIFO tail.
- Hold: a command that is presented but not accepted sets `lock` ← 1 and `lock_owner` ← grantee. The grant must not change until that command is accepted.
- Lock cannot overflow the FIFO: the read was eligible when presented, and `count` only decreases while locked.
- Return path:
  - `mN_readdata = s_readdata`.
  - `mN_readdatavalid = s_readdatavalid & FIFO_head == N & count != 0`.
  - On `s_readdatavalid` with `count != 0`, pop the FIFO head.
- Orphan return: `s_readdatavalid` with `count == 0` sets `err_orphan` (cleared only by reset). No pop occurs and no master is signalled.
- Same-cycle push and pop: both take effect; `count` is unchanged; the pointers each advance.
- While `reset_reset` is high (overrides all combinational outputs):
  - `s_read` = `s_write` = 0.
  - `mN_waitrequest` = 1.
  - `mN_readdatavalid` = 0.

## Timing
- Reset values after the edge with `reset_reset` = 1: `last` = 1 (master 0 wins first), `lock` = 0, `count` = 0, FIFO pointers = 0, `err_orphan` = 0.
- Reset mid-operation: all outstanding tags are discarded. Any `s_readdatavalid` that returns after reset counts as an orphan.
- Command path: zero-cycle combinational, master → slave and `s_waitrequest` → master. No added latency.
- Return path: zero-cycle combinational. `mN_readdatavalid` is asserted in the same cycle as `s_readdatavalid`.
- Grant, lock and FIFO updates take effect on the rising edge following accept or return.
- Back-to-back accepts alternate between masters every cycle when both are continuously eligible.
- FIFO full (`count == MAX_PENDING`):
  - Reads stall with waitrequest = 1; writes still pass.
  - A pop in cycle T makes reads eligible again in cycle T+1.

## Test plan
- Reset, then `m0_read` addr 0x10 only with `s_waitrequest` = 0:
  - `s_read` = 1, `s_address` = 0x10, `m0_waitrequest` = 0 in the same cycle.
  - Three cycles later, `s_readdatavalid` with 0xCAFEF00D → `m0_readdatavalid` = 1, `m1_readdatavalid` = 0.
- Both masters write continuously with `s_waitrequest` = 0 → accepted order m0, m1, m0, m1, …
- `s_waitrequest` held high 4 cycles while m0 is presented, then m1 also requests → `s_address` stays m0's for all 4 cycles; m1 is granted the cycle after m0 is accepted.
- Interleaved reads m0, m1, m1, m0 accepted, then 4 `s_readdatavalid` pulses → valids route to m0, m1, m1, m0 in order.
- 8 reads accepted with no return → 9th read sees waitrequest = 1 and `s_read` = 0 while a write from the other master is accepted. One return re-enables the read the next cycle.
- `s_readdatavalid` with `count` = 0 → `err_orphan` = 1 and no `mN_readdatavalid`. `reset_reset` pulse → `err_orphan` = 0.
